// File: rtl/cla_slice_sequencer.sv
// ---------------------------------------------------------------------------
// cla_slice_sequencer
//   Computes a W-bit sum {cout, s} = a + b + cin by running one shared N-bit
//   carry-lookahead slice over K = W/N cycles, least-significant slice first.
//   The carry ripples between slices through carry_reg. Group propagate and
//   group generate are accumulated across slices so that prop and gen match
//   a full-width CLA.
//
//   Ports:
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset
//     start  in   request pulse, honoured only in IDLE or DONE
//     cin    in   carry-in, captured on an accepted start
//     a, b   in   W-bit operands, captured on an accepted start
//     busy   out  high while the operation is in RUN
//     done   out  one-cycle pulse; results valid from this cycle onward
//     s      out  W-bit sum, held until the next accepted start
//     cout   out  carry-out of the most significant slice
//     prop   out  group propagate (AND of all slice propagates)
//     gen    out  group generate over the full width
//
//   W must be an integer multiple of N.
// ---------------------------------------------------------------------------

// Combinational N-bit CLA slice.
module cla_slice #(
   parameter int N = 32
) (
   input  logic         cin,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] s,
   output logic         prop,
   output logic         gen,
   output logic         cout
);
   logic [N-1:0] p;
   logic [N-1:0] g;
   logic [N:0]   c;
   logic [N:0]   gg;

   for (genvar gi = 0; gi < N; gi++) begin : g_bit
      assign p[gi] = a[gi] ^ b[gi];
      assign g[gi] = a[gi] & b[gi];
      assign s[gi] = p[gi] ^ c[gi];
   end

   // Carry and group-generate recurrences; synthesis flattens these into
   // lookahead terms.
   always_comb begin
      c     = '0;
      gg    = '0;
      c[0]  = cin;
      gg[0] = 1'b0;
      for (int i = 0; i < N; i++) begin
         c[i+1]  = g[i] | (p[i] & c[i]);
         gg[i+1] = g[i] | (p[i] & gg[i]);
      end
   end

   assign prop = &p;
   assign gen  = gg[N];
   assign cout = c[N];
endmodule

module cla_slice_sequencer #(
   parameter int W = 128,
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         cin,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] s,
   output logic         cout,
   output logic         prop,
   output logic         gen
);
   localparam int K  = W / N;
   localparam int IW = (K > 1) ? $clog2(K) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_reg, state_next;
   logic [IW-1:0] idx_reg;
   logic          carry_reg;
   logic          p_reg;
   logic          g_reg;
   logic [W-1:0]  a_reg;
   logic [W-1:0]  b_reg;
   logic [W-1:0]  s_reg;

   logic          accept;
   logic          last;
   logic [N-1:0]  sl_a, sl_b, sl_s;
   logic          sl_p, sl_g, sl_c;

   assign accept = start && (state_reg == IDLE || state_reg == DONE);
   assign last   = (idx_reg == IW'(K - 1));

   assign sl_a = a_reg[int'(idx_reg)*N +: N];
   assign sl_b = b_reg[int'(idx_reg)*N +: N];

   cla_slice #(.N(N)) u_slice (
      .cin  (carry_reg),
      .a    (sl_a),
      .b    (sl_b),
      .s    (sl_s),
      .prop (sl_p),
      .gen  (sl_g),
      .cout (sl_c)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last)  state_next = DONE;
         DONE:    state_next = start ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         carry_reg <= 1'b0;
         p_reg     <= 1'b0;
         g_reg     <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         s_reg     <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx_reg   <= '0;
            p_reg     <= 1'b1;
            g_reg     <= 1'b0;
         end else if (state_reg == RUN) begin
            s_reg[int'(idx_reg)*N +: N] <= sl_s;
            carry_reg <= sl_c;
            p_reg     <= p_reg & sl_p;
            // Higher slice generates, or propagates what lower slices generated.
            g_reg     <= sl_g | (sl_p & g_reg);
            // Explicit wrap keeps non-power-of-two K well defined.
            idx_reg   <= last ? '0 : idx_reg + 1'b1;
         end
      end
   end

   // After the last slice carry_reg holds the final carry-out; it is
   // reloaded with cin only when the next operation is accepted.
   assign busy = (state_reg == RUN);
   assign done = (state_reg == DONE);
   assign s    = s_reg;
   assign cout = carry_reg;
   assign prop = p_reg;
   assign gen  = g_reg;
endmodule

// File: tb/tb_cla_slice_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cla_slice_sequencer
//   Scoreboard bench: each accepted start pushes the reference result and the
//   accept edge index; each observed done pops and compares the result and
//   the start-to-done latency.
// ---------------------------------------------------------------------------
module tb_cla_slice_sequencer;
   localparam int W  = 128;
   localparam int N  = 32;
   localparam int K  = W / N;
   localparam int W1 = W + 1;
   localparam int N_STREAM = 3000;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         cin;
   logic [W-1:0] a, b;
   logic         busy, done, cout, prop, gen;
   logic [W-1:0] s;

   typedef struct {
      logic [W-1:0] s;
      logic         cout;
      logic         prop;
      logic         gen;
      int           acc;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   n_ops = 0;

   cla_slice_sequencer #(.W(W), .N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .cin   (cin),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .s     (s),
      .cout  (cout),
      .prop  (prop),
      .gen   (gen)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [W:0] obs, input logic [W:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Full-width reference adder. Group generate equals the carry-out of
   // a + b with no carry-in.
   function automatic exp_t ref_adder(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                      input logic rc);
      exp_t       e;
      logic [W:0] sum;
      logic [W:0] sum0;
      sum    = {1'b0, ra} + {1'b0, rb} + W1'(rc);
      sum0   = {1'b0, ra} + {1'b0, rb};
      e.s    = sum[W-1:0];
      e.cout = sum[W];
      e.prop = &(ra ^ rb);
      e.gen  = sum0[W];
      e.acc  = 0;
      return e;
   endfunction

   // Called at a negedge; the start is accepted at the following posedge.
   task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
      exp_t e;
      start = 1'b1;
      a     = ta;
      b     = tb_v;
      cin   = tc;
      e     = ref_adder(ta, tb_v, tc);
      e.acc = cyc + 1;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!done) check_val("done_timeout", W1'(done), W1'(1));
   endtask

   task automatic check_zero_outputs(input string tag);
      check_val({tag, "_busy"}, W1'(busy), '0);
      check_val({tag, "_done"}, W1'(done), '0);
      check_val({tag, "_s"},    W1'(s),    '0);
      check_val({tag, "_cout"}, W1'(cout), '0);
      check_val({tag, "_prop"}, W1'(prop), '0);
      check_val({tag, "_gen"},  W1'(gen),  '0);
   endtask

   // Monitor: one line per completed transaction.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && done) begin
            if (q.size() == 0) begin
               check_val("spurious_done", W1'(done), W1'(0));
            end else begin
               e = q.pop_front();
               n_ops++;
               check_val("sb_s",    W1'(s),    W1'(e.s));
               check_val("sb_cout", W1'(cout), W1'(e.cout));
               check_val("sb_prop", W1'(prop), W1'(e.prop));
               check_val("sb_gen",  W1'(gen),  W1'(e.gen));
               check_val("sb_latency", W1'(cyc - e.acc), W1'(K));
               if (n_ops <= 8 || n_ops % 500 == 0)
                  $display("op %0d: s=%h cout=%0b prop=%0b gen=%0b", n_ops, s, cout, prop, gen);
            end
         end
      end
   end

   initial begin
      logic [W-1:0] ones;
      logic [W-1:0] msb;
      int           n;

      rst_n = 1'b0;
      start = 1'b0;
      cin   = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // all ones + 0 + 1: carry ripples through every slice
      ones = '1;
      start_op(ones, '0, 1'b1);
      for (int i = 0; i < K; i++) begin
         check_val("t1_busy", W1'(busy), W1'(1));
         check_val("t1_done_early", W1'(done), W1'(0));
         @(negedge clk);
      end
      check_val("t1_busy_done", W1'(busy), W1'(0));
      check_val("t1_done", W1'(done), W1'(1));
      check_val("t1_s",    W1'(s),    W1'(0));
      check_val("t1_cout", W1'(cout), W1'(1));
      check_val("t1_prop", W1'(prop), W1'(1));
      check_val("t1_gen",  W1'(gen),  W1'(0));
      repeat (2) @(negedge clk);

      // carry crossing slice 0 -> 1
      start_op({96'h0, 32'hFFFF_FFFF}, 128'h1, 1'b0);
      wait_done();
      check_val("t2_s",    W1'(s),    W1'(128'h1_0000_0000));
      check_val("t2_cout", W1'(cout), W1'(0));
      check_val("t2_prop", W1'(prop), W1'(0));
      check_val("t2_gen",  W1'(gen),  W1'(0));
      @(negedge clk);

      // MSB generate
      msb = '0;
      msb[W-1] = 1'b1;
      start_op(msb, msb, 1'b0);
      wait_done();
      check_val("t3_s",    W1'(s),    W1'(0));
      check_val("t3_cout", W1'(cout), W1'(1));
      check_val("t3_prop", W1'(prop), W1'(0));
      check_val("t3_gen",  W1'(gen),  W1'(1));
      @(negedge clk);

      // start during RUN is ignored
      start_op(128'd5, 128'd7, 1'b0);
      @(negedge clk);
      start = 1'b1;
      a     = 128'd1;
      b     = 128'd1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      check_val("t4_s", W1'(s), W1'(12));
      repeat (8) @(negedge clk);

      // asynchronous reset mid-operation
      start_op(128'd9, 128'd9, 1'b1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero_outputs("t5_rst");
      void'(q.pop_back());
      @(negedge clk);
      rst_n = 1'b1;
      start_op(128'd3, 128'd4, 1'b0);
      wait_done();
      check_val("t5_s", W1'(s), W1'(7));
      repeat (3) @(negedge clk);

      // back-to-back stream with start held high
      for (int i = 0; i < N_STREAM; i++) begin
         exp_t e;
         start = 1'b1;
         a     = {$urandom, $urandom, $urandom, $urandom};
         b     = {$urandom, $urandom, $urandom, $urandom};
         cin   = 1'($urandom);
         e     = ref_adder(a, b, cin);
         e.acc = cyc + 1;
         q.push_back(e);
         repeat (K + 1) @(negedge clk);
      end
      start = 1'b0;

      n = 0;
      while (q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_val("drain_pending", W1'(q.size()), W1'(0));
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
